// File: rtl/simon_playback.sv
// -----------------------------------------------------------------------------
// simon_playback
//
// Plays the stored Simon colour sequence back to the player. On an accepted
// start pulse it walks sequence RAM addresses 0..round_len-1. Each step spends
// one FETCH cycle waiting for the RAM word, then lights the colour LED for
// ON_TICKS cycles and blanks for GAP_TICKS cycles. A single-cycle done pulse
// ends the playback.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   start      single-cycle playback request, honoured only when idle
//   round_len  number of steps to play (0..31), sampled on accepted start
//   mem_addr   registered sequence RAM read address
//   mem_data   colour code from RAM, sampled at the end of the FETCH cycle
//   led        one-hot colour drive (code n -> bit n), 0 when dark
//   busy       high from the cycle after an accepted start through done
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module simon_playback #(
   parameter int ON_TICKS  = 25000000,
   parameter int GAP_TICKS = 12500000,
   parameter int CNT_W     = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] round_len,
   output logic [4:0] mem_addr,
   input  logic [1:0] mem_data,
   output logic [3:0] led,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SHOW  = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

   state_t           state_reg, state_next;
   logic [4:0]       len_reg, len_next;
   logic [4:0]       idx_reg, idx_next;
   logic [4:0]       mem_addr_reg, mem_addr_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       led_reg, led_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   // Colour code to LED one-hot decode of the RAM word.
   logic [3:0] colour_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_decode
         assign colour_onehot[gi] = (mem_data == 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         len_reg      <= 5'd0;
         idx_reg      <= 5'd0;
         mem_addr_reg <= 5'd0;
         cnt_reg      <= '0;
         led_reg      <= 4'd0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         idx_reg      <= idx_next;
         mem_addr_reg <= mem_addr_next;
         cnt_reg      <= cnt_next;
         led_reg      <= led_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   // Outputs are computed one cycle ahead so that every port comes straight
   // from a register: led/busy/done take the value of the state being entered.
   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      idx_next      = idx_reg;
      mem_addr_next = mem_addr_reg;
      cnt_next      = cnt_reg;
      led_next      = led_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            led_next  = 4'd0;
            busy_next = 1'b0;
            if (start) begin
               busy_next = 1'b1;
               if (round_len != 5'd0) begin
                  len_next      = round_len;
                  idx_next      = 5'd0;
                  mem_addr_next = 5'd0;
                  state_next    = FETCH;
               end else begin
                  // Empty round: report completion immediately, address untouched.
                  done_next  = 1'b1;
                  state_next = DONE;
               end
            end
         end

         FETCH: begin
            // mem_addr has been stable for this whole cycle, so the word is ready.
            led_next   = colour_onehot;
            cnt_next   = '0;
            state_next = SHOW;
         end

         SHOW: begin
            if (cnt_reg == ON_LAST) begin
               cnt_next   = '0;
               led_next   = 4'd0;
               state_next = GAP;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         GAP: begin
            if (cnt_reg == GAP_LAST) begin
               cnt_next = '0;
               if (idx_reg == len_reg - 5'd1) begin
                  done_next  = 1'b1;
                  state_next = DONE;
               end else begin
                  idx_next      = idx_reg + 5'd1;
                  mem_addr_next = idx_reg + 5'd1;
                  state_next    = FETCH;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         DONE: begin
            // start is deliberately ignored here; a new request needs IDLE.
            led_next   = 4'd0;
            busy_next  = 1'b0;
            state_next = IDLE;
         end

         default: begin
            led_next   = 4'd0;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   assign mem_addr = mem_addr_reg;
   assign led      = led_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;

endmodule

// File: tb/tb_simon_playback.sv
// -----------------------------------------------------------------------------
// tb_simon_playback
//
// Two instances: dut0 with ON_TICKS=3/GAP_TICKS=2 and dut1 with the minimum
// ON_TICKS=1/GAP_TICKS=1. A shared sequence RAM feeds both; its word for the
// registered address is available within the FETCH cycle. For every playback
// the expected per-cycle trace {busy, done, led, mem_addr} is built from the
// step timing rules and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_simon_playback;

   localparam int ON0 = 3, GAP0 = 2;
   localparam int ON1 = 1, GAP1 = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [4:0] rl0 = 5'd0, rl1 = 5'd0;
   logic [4:0] a0, a1;
   logic [1:0] d0, d1;
   logic [3:0] led0, led1;
   logic       busy0, busy1, done0, done1;

   logic [1:0] ram [0:31];

   int n_cmp = 0;
   int n_bad = 0;
   int sel   = 0;
   logic [4:0] last_addr [0:1];

   always #5 clk = ~clk;

   assign d0 = ram[a0];
   assign d1 = ram[a1];

   simon_playback #(.ON_TICKS(ON0), .GAP_TICKS(GAP0), .CNT_W(2)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .round_len(rl0),
      .mem_addr(a0), .mem_data(d0), .led(led0), .busy(busy0), .done(done0)
   );

   simon_playback #(.ON_TICKS(ON1), .GAP_TICKS(GAP1), .CNT_W(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .round_len(rl1),
      .mem_addr(a1), .mem_data(d1), .led(led1), .busy(busy1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [10:0] observe(input int which);
      if (which == 1) return {busy1, done1, led1, a1};
      return {busy0, done0, led0, a0};
   endfunction

   task automatic drive(input logic st, input logic [4:0] rl);
      if (sel == 1) begin
         start1 = st;
         rl1    = rl;
      end else begin
         start0 = st;
         rl0    = rl;
      end
   endtask

   // Plays one round on the selected instance. reset_at >= 0 asserts reset
   // while the trace is in that cycle; disturb re-pulses start and scrambles
   // round_len at a random cycle of the playback.
   task automatic play(input int len, input int reset_at, input bit disturb);
      logic [10:0] q[$];
      int on_t, gap_t, dpos, n;
      bit aborted;
      logic [4:0] end_addr;
      on_t  = (sel == 1) ? ON1 : ON0;
      gap_t = (sel == 1) ? GAP1 : GAP0;
      end_addr = (len > 0) ? 5'(len - 1) : last_addr[sel];
      for (int s = 0; s < len; s++) begin
         q.push_back({1'b1, 1'b0, 4'd0, 5'(s)});
         for (int t = 0; t < on_t; t++) q.push_back({1'b1, 1'b0, 4'b0001 << ram[s], 5'(s)});
         for (int t = 0; t < gap_t; t++) q.push_back({1'b1, 1'b0, 4'd0, 5'(s)});
      end
      q.push_back({1'b1, 1'b1, 4'd0, end_addr});
      q.push_back({1'b0, 1'b0, 4'd0, end_addr});
      dpos = disturb ? $urandom_range(0, q.size() - 2) : -1;
      aborted = 1'b0;
      n = q.size();

      drive(1'b1, 5'(len));
      @(posedge clk); #1;
      drive(1'b0, 5'(len));
      for (int i = 0; i < n && !aborted; i++) begin
         if (i == reset_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            check("reset_mid", {21'd0, observe(sel)}, 32'd0);
            reset = 1'b0;
            last_addr[0] = 5'd0;
            last_addr[1] = 5'd0;
            aborted = 1'b1;
         end else begin
            check($sformatf("play%0d_len%0d_c%0d", sel, len, i), {21'd0, observe(sel)}, {21'd0, q[i]});
            if (i == dpos) drive(1'b1, 5'($urandom_range(0, 31)));
            else drive(1'b0, 5'(len));
            @(posedge clk); #1;
         end
      end
      drive(1'b0, 5'd0);
      if (!aborted) last_addr[sel] = end_addr;
      $display("play: dut%0d len=%0d reset_at=%0d disturb=%0d cycles=%0d cmp=%0d bad=%0d",
               sel, len, reset_at, disturb, n, n_cmp, n_bad);
   endtask

   task automatic fill_ram();
      for (int i = 0; i < 32; i++) ram[i] = 2'($urandom_range(0, 3));
   endtask

   initial begin
      last_addr[0] = 5'd0;
      last_addr[1] = 5'd0;
      fill_ram();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_dut0", {21'd0, observe(0)}, 32'd0);
      check("reset_dut1", {21'd0, observe(1)}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      sel = 0;
      ram[0] = 2'd2;
      play(1, -1, 1'b0);
      ram[0] = 2'd0; ram[1] = 2'd3; ram[2] = 2'd1;
      play(3, -1, 1'b0);
      play(0, -1, 1'b0);
      play(2, -1, 1'b1);
      // Reset during the GAP of step 1: step 1 occupies trace cycles 6..11.
      play(3, 1 + ON0 + GAP0 + 1 + ON0, 1'b0);
      fill_ram();
      play(1, -1, 1'b0);

      for (int k = 0; k < 10; k++) begin
         fill_ram();
         play($urandom_range(0, 8), -1, 1'($urandom_range(0, 1)));
      end

      sel = 1;
      fill_ram();
      play(31, -1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         fill_ram();
         play($urandom_range(0, 31), -1, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
